ir_cmd_ctrl: RTL and testbench

Command controller between the IR receiver and the display/application logic. It accepts decoded 32-bit NEC frames and repeat-code strobes, and validates address and command complement. It converts each accepted key press and each held-key repeat into command tokens, and buffers them in a 4-entry FIFO drained by a valid/ready consumer. It also counts rejected frames and dropped commands for debug display on the six-digit LED.

---
 rtl/ir_pkg.sv | 28 ++
 rtl/ir_cmd_fifo.sv | 69 ++++++
 rtl/ir_cmd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ir_cmd_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the IR command controller.
//   - controller state encoding
//   - bit positions of the fields inside a decoded 32-bit NEC frame
//   - default address / repeat timing constants and FIFO geometry
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PUSH,
    ST_HELD
  } ir_state_t;

  localparam int ADDR_MSB = 31;
  localparam int ADDR_LSB = 16;
  localparam int CMD_MSB  = 15;
  localparam int CMD_LSB  = 8;
  localparam int CMDN_MSB = 7;
  localparam int CMDN_LSB = 0;

  localparam logic [15:0] DEF_ADDR         = 16'h00FF;
  localparam int          DEF_RPT_DELAY_MS = 300;
  localparam int          DEF_RPT_TO_MS    = 120;

  localparam int FIFO_DEPTH = 4;
  localparam int TOKEN_W    = 9;

endpackage

// File: rtl/ir_cmd_fifo.sv
// ir_cmd_fifo: 4-entry x 9-bit synchronous FIFO for command tokens.
// The head entry is held in its own register so the consumer sees a
// stable, glitch-free value, and the next entry follows a pop with no
// bubble. A push into a full FIFO is discarded and reported on 'drop',
// unless a pop happens in the same cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data this cycle
//   push_data   token {rpt, cmd}
//   ready       consumer accepts the head this cycle
//   valid       head holds a token
//   head        current head token
//   drop        one-cycle pulse: a push was lost to a full FIFO
module ir_cmd_fifo
  import ir_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [TOKEN_W-1:0] push_data,
  input  logic               ready,
  output logic               valid,
  output logic [TOKEN_W-1:0] head,
  output logic               drop
);

  logic [TOKEN_W-1:0] mem [FIFO_DEPTH];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [1:0]         rd_next;
  logic [2:0]         count;
  logic               full;
  logic               pop;
  logic               accept;

  assign valid   = (count != 3'd0);
  assign full    = (count == 3'(FIFO_DEPTH));
  assign pop     = valid & ready;
  // A pop frees the slot before the push lands, so full+pop+push is legal.
  assign accept  = push & (!full | pop);
  assign drop    = push & full & !pop;
  assign rd_next = rd_ptr + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_next;
      count <= count + {2'd0, accept} - {2'd0, pop};
      // With two or more entries the successor is already in memory;
      // otherwise the only candidate for the new head is the incoming push.
      if (pop) begin
        if (count >= 3'd2) head <= mem[rd_next];
        else if (accept)   head <= push_data;
      end else if (accept && count == 3'd0) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: turns decoded NEC frames and repeat strobes into command
// tokens. A frame with a correct command complement (and matching address
// when ADDR_CHK=1) produces one initial-press token; while the key stays
// held, repeat codes arriving after RPT_DELAY_MS produce auto-repeat
// tokens. The key is released after RPT_TO_MS without a repeat code.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_tick_1ms      1 ms strobe
//   i_frame_valid   new frame on i_frame
//   i_frame         {address, command, ~command}
//   i_repeat        NEC repeat code strobe
//   o_cmd_valid, o_cmd, o_cmd_rpt, i_cmd_ready   token stream (valid/ready)
//   o_err_cnt       rejected/dropped frames, saturating
//   o_drop_cnt      tokens lost to a full FIFO, saturating
//   o_held          key currently held
module ir_cmd_ctrl
  import ir_pkg::*;
#(
  parameter logic [15:0] ADDR         = DEF_ADDR,
  parameter bit          ADDR_CHK     = 1'b1,
  parameter int          RPT_DELAY_MS = DEF_RPT_DELAY_MS,
  parameter int          RPT_TO_MS    = DEF_RPT_TO_MS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tick_1ms,
  input  logic        i_frame_valid,
  input  logic [31:0] i_frame,
  input  logic        i_repeat,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_rpt,
  input  logic        i_cmd_ready,
  output logic [7:0]  o_err_cnt,
  output logic [7:0]  o_drop_cnt,
  output logic        o_held
);

  localparam logic [15:0] RPT_DELAY_W = 16'(RPT_DELAY_MS);
  localparam logic [15:0] RPT_TO_W    = 16'(RPT_TO_MS);

  ir_state_t    state;
  logic [31:0]  frame_q;
  logic [7:0]   cmd_q;
  logic         rpt_q;
  logic [15:0]  hold_ms;
  logic [15:0]  gap_ms;
  logic [15:0]  hold_inc;
  logic [15:0]  gap_inc;
  logic         frame_ok;
  logic [1:0]   err_inc;
  logic [8:0]   err_sum;
  logic         push;
  logic         drop;
  logic [TOKEN_W-1:0] head;

  assign hold_inc = (hold_ms == 16'hFFFF) ? hold_ms : hold_ms + 16'd1;
  assign gap_inc  = gap_ms + 16'd1;
  assign push     = (state == ST_PUSH);

  // Frame validation and error accounting. A bad frame in CHECK and a
  // frame arriving while busy can both land in the same cycle.
  always_comb begin
    frame_ok = (frame_q[CMD_MSB:CMD_LSB] == ~frame_q[CMDN_MSB:CMDN_LSB]) &&
               (!ADDR_CHK || frame_q[ADDR_MSB:ADDR_LSB] == ADDR);
    err_inc = 2'd0;
    if (state == ST_CHECK && !frame_ok) err_inc = err_inc + 2'd1;
    if (i_frame_valid && (state == ST_CHECK || state == ST_PUSH)) err_inc = err_inc + 2'd1;
    err_sum = {1'b0, o_err_cnt} + {7'd0, err_inc};
  end

  // Controller FSM. o_held is registered alongside the state so it is
  // high exactly while the state is HELD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      frame_q <= '0;
      cmd_q   <= '0;
      rpt_q   <= 1'b0;
      hold_ms <= '0;
      gap_ms  <= '0;
      o_held  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_frame_valid) begin
            frame_q <= i_frame;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (frame_ok) begin
            cmd_q <= frame_q[CMD_MSB:CMD_LSB];
            rpt_q <= 1'b0;
            state <= ST_PUSH;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PUSH: begin
          // Auto-repeats keep counting hold time from the original press.
          gap_ms <= '0;
          if (!rpt_q) hold_ms <= '0;
          state  <= ST_HELD;
          o_held <= 1'b1;
        end
        ST_HELD: begin
          if (i_frame_valid) begin
            frame_q <= i_frame;
            state   <= ST_CHECK;
            o_held  <= 1'b0;
          end else begin
            if (i_tick_1ms) begin
              hold_ms <= hold_inc;
              gap_ms  <= gap_inc;
            end
            if (i_repeat) begin
              gap_ms <= '0;
              if (hold_ms >= RPT_DELAY_W) begin
                rpt_q  <= 1'b1;
                state  <= ST_PUSH;
                o_held <= 1'b0;
              end
            end else if (i_tick_1ms && gap_inc >= RPT_TO_W) begin
              state  <= ST_IDLE;
              o_held <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_held <= 1'b0;
        end
      endcase
    end
  end

  // Saturating debug counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      o_err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  ir_cmd_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({rpt_q, cmd_q}),
    .ready     (i_cmd_ready),
    .valid     (o_cmd_valid),
    .head      (head),
    .drop      (drop)
  );

  assign o_cmd     = head[7:0];
  assign o_cmd_rpt = head[8];

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb_ir_cmd_ctrl: testbench for ir_cmd_ctrl. A table of frames checks
// timing and validation, directed sequences cover release, busy frames,
// FIFO overflow, auto-repeat and reset, and a random event stream is
// checked against an event-level model of key press / hold / release.
module tb_ir_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_tick_1ms;
  logic        i_frame_valid;
  logic [31:0] i_frame;
  logic        i_repeat;
  logic        o_cmd_valid;
  logic [7:0]  o_cmd;
  logic        o_cmd_rpt;
  logic        i_cmd_ready;
  logic [7:0]  o_err_cnt;
  logic [7:0]  o_drop_cnt;
  logic        o_held;

  always #5 clk = ~clk;

  ir_cmd_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tick_1ms    (i_tick_1ms),
    .i_frame_valid (i_frame_valid),
    .i_frame       (i_frame),
    .i_repeat      (i_repeat),
    .o_cmd_valid   (o_cmd_valid),
    .o_cmd         (o_cmd),
    .o_cmd_rpt     (o_cmd_rpt),
    .i_cmd_ready   (i_cmd_ready),
    .o_err_cnt     (o_err_cnt),
    .o_drop_cnt    (o_drop_cnt),
    .o_held        (o_held)
  );

  int total = 0;
  int bad   = 0;

  // Event-level model: key held flag, ms since press, ms since last repeat.
  logic [8:0] mq[$];
  bit         m_held;
  int         m_hold;
  int         m_gap;
  logic [7:0] m_last;
  int         err_exp;
  int         drop_exp;

  typedef struct {
    logic [31:0] frame;
    bit          exp_valid;
    logic [7:0]  exp_cmd;
    int          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit frame_good(input logic [31:0] f);
    return (f[15:8] == ~f[7:0]) && (f[31:16] == 16'h00FF);
  endfunction

  task automatic model_push(input logic [8:0] tok);
    if (mq.size() >= 4) begin
      if (drop_exp < 255) drop_exp++;
    end else begin
      mq.push_back(tok);
    end
  endtask

  task automatic model_frame(input logic [31:0] f);
    if (frame_good(f)) begin
      model_push({1'b0, f[15:8]});
      m_held = 1'b1;
      m_hold = 0;
      m_gap  = 0;
      m_last = f[15:8];
    end else begin
      if (err_exp < 255) err_exp++;
      m_held = 1'b0;
    end
  endtask

  task automatic model_tick();
    if (m_held) begin
      if (m_hold < 65535) m_hold++;
      m_gap++;
      if (m_gap >= 120) m_held = 1'b0;
    end
  endtask

  task automatic model_repeat();
    if (m_held) begin
      m_gap = 0;
      if (m_hold >= 300) model_push({1'b1, m_last});
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_held   = 1'b0;
    m_hold   = 0;
    m_gap    = 0;
    m_last   = '0;
    err_exp  = 0;
    drop_exp = 0;
  endtask

  task automatic check_state(input string tag);
    check_output({tag, "_held"},  32'(o_held),      32'(m_held));
    check_output({tag, "_err"},   32'(o_err_cnt),   err_exp);
    check_output({tag, "_drop"},  32'(o_drop_cnt),  drop_exp);
    check_output({tag, "_valid"}, 32'(o_cmd_valid), 32'(mq.size() != 0));
  endtask

  // One event slot: pulse the inputs for one cycle, then let the FSM settle.
  task automatic apply_stimulus(input bit fv, input logic [31:0] f, input bit rp, input bit tk,
                                input string tag);
    @(negedge clk);
    i_frame_valid = fv;
    i_frame       = f;
    i_repeat      = rp;
    i_tick_1ms    = tk;
    @(negedge clk);
    i_frame_valid = 1'b0;
    i_repeat      = 1'b0;
    i_tick_1ms    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (fv) model_frame(f);
    else begin
      if (tk) model_tick();
      if (rp) model_repeat();
    end
    check_state(tag);
  endtask

  // Drain every expected token, one per cycle; caller sits at a negedge.
  task automatic drain(input string tag);
    while (mq.size() > 0) begin
      check_output({tag, "_dvalid"}, 32'(o_cmd_valid), 32'd1);
      check_output({tag, "_dhead"},  32'({o_cmd_rpt, o_cmd}), 32'(mq[0]));
      i_cmd_ready = 1'b1;
      void'(mq.pop_front());
      @(negedge clk);
    end
    check_output({tag, "_dempty"}, 32'(o_cmd_valid), 32'd0);
    i_cmd_ready = 1'b0;
  endtask

  function automatic logic [31:0] mk_frame(input logic [7:0] c);
    return {16'h00FF, c, ~c};
  endfunction

  initial begin
    int rpt_seen;
    int r;
    logic [7:0]  c;
    logic [15:0] a;
    logic [7:0]  flip;

    vecs[0] = '{32'h00FF_45BA, 1'b1, 8'h45, 0};
    vecs[1] = '{32'h00FF_4545, 1'b0, 8'h00, 1};
    vecs[2] = '{32'h1234_45BA, 1'b0, 8'h00, 2};
    vecs[3] = '{32'h00FF_16E9, 1'b1, 8'h16, 2};
    vecs[4] = '{32'h00FF_00FF, 1'b1, 8'h00, 2};
    vecs[5] = '{32'h00FF_FF00, 1'b1, 8'hFF, 2};
    vecs[6] = '{32'h00FE_08F7, 1'b0, 8'h00, 3};
    vecs[7] = '{32'h00FF_0CF3, 1'b1, 8'h0C, 3};

    rst_n = 1'b0;
    i_tick_1ms = 1'b0; i_frame_valid = 1'b0; i_frame = '0; i_repeat = 1'b0; i_cmd_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_output("rst_valid", 32'(o_cmd_valid), 32'd0);
    check_output("rst_cmd",   32'({o_cmd_rpt, o_cmd}), 32'd0);
    check_output("rst_err",   32'(o_err_cnt), 32'd0);
    check_output("rst_drop",  32'(o_drop_cnt), 32'd0);
    check_output("rst_held",  32'(o_held), 32'd0);
    rst_n = 1'b1;

    // Table: latency N+3, validation, error count.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_frame_valid = 1'b1;
      i_frame       = vecs[i].frame;
      @(negedge clk);
      i_frame_valid = 1'b0;
      check_output("tbl_lat1", 32'(o_cmd_valid), 32'd0);
      @(negedge clk);
      check_output("tbl_lat2", 32'(o_cmd_valid), 32'd0);
      @(negedge clk);
      check_output("tbl_valid", 32'(o_cmd_valid), 32'(vecs[i].exp_valid));
      check_output("tbl_err",   32'(o_err_cnt),   vecs[i].exp_err);
      if (vecs[i].exp_valid) begin
        check_output("tbl_cmd",  32'(o_cmd),     32'(vecs[i].exp_cmd));
        check_output("tbl_rpt",  32'(o_cmd_rpt), 32'd0);
        check_output("tbl_held", 32'(o_held),    32'd1);
      end
      model_frame(vecs[i].frame);
      drain("tbl");
    end

    // Release after 120 ticks without a repeat.
    apply_stimulus(1'b1, 32'h00FF_45BA, 1'b0, 1'b0, "rel_frame");
    drain("rel");
    for (int t = 0; t < 119; t++) apply_stimulus(1'b0, '0, 1'b0, 1'b1, "rel_tick");
    check_output("rel_held119", 32'(o_held), 32'd1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, "rel_tick120");
    check_output("rel_held120", 32'(o_held), 32'd0);

    // Frames arriving during CHECK and PUSH are dropped and counted.
    @(negedge clk);
    i_frame_valid = 1'b1; i_frame = 32'h00FF_20DF;
    @(negedge clk);
    i_frame = 32'h00FF_21DE;
    @(negedge clk);
    i_frame = 32'h00FF_22DD;
    @(negedge clk);
    i_frame_valid = 1'b0;
    @(negedge clk);
    model_frame(32'h00FF_20DF);
    err_exp += 2;
    check_state("busy");
    drain("busy");

    // Overflow: six presses with the consumer stalled.
    for (int k = 0; k < 6; k++) apply_stimulus(1'b1, mk_frame(8'h30 + 8'(k)), 1'b0, 1'b0, "ovf");
    check_output("ovf_drop2", 32'(o_drop_cnt), 32'd2);
    check_output("ovf_hold0", 32'(o_cmd), 32'h30);
    @(negedge clk);
    check_output("ovf_hold1", 32'(o_cmd), 32'h30);
    drain("ovf");

    // Auto-repeat: repeats every 108 ms for one second.
    apply_stimulus(1'b1, mk_frame(8'h16), 1'b0, 1'b0, "rpt_frame");
    drain("rpt0");
    rpt_seen = 0;
    for (int t = 1; t <= 1000; t++) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b1, "rpt_tick");
      if (t % 108 == 0) begin
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, "rpt_rep");
        if (o_cmd_valid && o_cmd_rpt && o_cmd == 8'h16) rpt_seen++;
        drain("rpt");
      end
    end
    check_output("rpt_count", 32'(rpt_seen), 32'd7);

    // Frame and repeat together while held past the delay: frame wins.
    apply_stimulus(1'b1, 32'h00FF_08F7, 1'b1, 1'b0, "both");
    check_output("both_head", 32'({o_cmd_rpt, o_cmd}), 32'h008);
    drain("both");

    // Random event stream against the model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 999);
      c = 8'($urandom);
      if (r < 2) begin
        apply_stimulus(1'b1, mk_frame(c), 1'b0, 1'b0, "rnd_frame");
      end else if (r < 3) begin
        if ($urandom_range(0, 1) == 0) begin
          flip = 8'($urandom_range(1, 255));
          apply_stimulus(1'b1, {16'h00FF, c, ~c ^ flip}, 1'b0, 1'b0, "rnd_badc");
        end else begin
          a = 16'($urandom_range(256, 65535));
          apply_stimulus(1'b1, {a, c, ~c}, 1'b0, 1'b0, "rnd_bada");
        end
      end else if (r < 13) begin
        drain("rnd");
      end else if (r < 163) begin
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, "rnd_rep");
      end else begin
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, "rnd_tick");
      end
    end
    drain("rnd_end");

    // Reset mid-PUSH with two queued entries.
    apply_stimulus(1'b1, mk_frame(8'h51), 1'b0, 1'b0, "rst_q1");
    apply_stimulus(1'b1, mk_frame(8'h52), 1'b0, 1'b0, "rst_q2");
    @(negedge clk);
    i_frame_valid = 1'b1; i_frame = mk_frame(8'h53);
    @(negedge clk);
    i_frame_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("mid_valid", 32'(o_cmd_valid), 32'd0);
    check_output("mid_err",   32'(o_err_cnt),   32'd0);
    check_output("mid_drop",  32'(o_drop_cnt),  32'd0);
    check_output("mid_held",  32'(o_held),      32'd0);
    check_output("mid_cmd",   32'({o_cmd_rpt, o_cmd}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, mk_frame(8'h54), 1'b0, 1'b0, "post_rst");
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
